// File: rtl/ethernec_rx_framer.sv
// ============================================================================
//  Module   : ethernec_rx_framer
//  Brief    : NE2000 receive framer. Takes async byte pushes, writes payload
//             and a 4-byte receive header into the rx buffer.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ethernec_rx_framer #(
  parameter int FRAMESIZE = 1536,
  parameter int MINFRAME  = 14
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_begin,
  input  logic        rx_strobe,
  input  logic [7:0]  rx_byte,
  input  logic [7:0]  curr,
  input  logic [7:0]  pstart,
  input  logic [7:0]  pstop,
  output logic        buf_we,
  output logic [10:0] buf_addr,
  output logic [7:0]  buf_data,
  output logic        frame_valid,
  output logic [10:0] frame_len,
  output logic [7:0]  next_page,
  input  logic        frame_ack,
  output logic [7:0]  drop_cnt
);

  localparam logic [10:0] c_FRAMESIZE = 11'(FRAMESIZE);
  localparam logic [10:0] c_MINFRAME  = 11'(MINFRAME);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_HDR   = 2'd2,
    S_READY = 2'd3
  } state_t;

  state_t      r_state, w_next;
  logic [2:0]  r_begin_sync, r_stb_sync;
  logic [10:0] r_cnt, r_total, r_addr;
  logic [7:0]  r_data, r_next_page, r_drop;
  logic [1:0]  r_hcnt;
  logic        r_ovf, r_fall_pend, r_we;

  logic        w_begin_rise, w_begin_fall, w_stb_rise, w_end_frame, w_runt;
  logic [10:0] w_total;
  logic [2:0]  w_pages;
  logic [8:0]  w_np_raw;
  logic [7:0]  w_np;

  // Synchronisers are deliberately not reset so a begin held high across
  // reset is never mistaken for a fresh rising edge.
  always_ff @(posedge clk) begin
    r_begin_sync <= {r_begin_sync[1:0], rx_begin};
    r_stb_sync   <= {r_stb_sync[1:0], rx_strobe};
  end

  assign w_begin_rise = r_begin_sync[1] & ~r_begin_sync[2];
  assign w_begin_fall = ~r_begin_sync[1] & r_begin_sync[2];
  assign w_stb_rise   = r_stb_sync[1] & ~r_stb_sync[2];

  // A fall coinciding with a strobe is deferred one cycle so the byte lands first.
  assign w_end_frame = (r_state == S_RECV) && !w_stb_rise && (w_begin_fall || r_fall_pend);
  assign w_runt      = r_cnt < c_MINFRAME;

  assign w_total  = r_cnt + 11'd4;
  assign w_pages  = 3'((w_total + 11'd255) >> 8);
  assign w_np_raw = {1'b0, curr} + {6'd0, w_pages};
  assign w_np     = 8'((w_np_raw >= {1'b0, pstop}) ?
                       (w_np_raw - {1'b0, pstop} + {1'b0, pstart}) : w_np_raw);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_begin_rise) w_next = S_RECV;
      S_RECV:  if (w_end_frame) w_next = w_runt ? S_IDLE : S_HDR;
      S_HDR:   if (r_hcnt == 2'd3) w_next = S_READY;
      S_READY: if (frame_ack) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_total     <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_next_page <= '0;
      r_drop      <= '0;
      r_hcnt      <= '0;
      r_ovf       <= 1'b0;
      r_fall_pend <= 1'b0;
      r_we        <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        S_IDLE: if (w_begin_rise) begin
          r_cnt       <= '0;
          r_ovf       <= 1'b0;
          r_fall_pend <= 1'b0;
        end
        S_RECV: begin
          if (w_stb_rise) begin
            if (r_cnt < c_FRAMESIZE) begin
              r_we   <= 1'b1;
              r_addr <= r_cnt + 11'd4;
              r_data <= rx_byte;
              r_cnt  <= r_cnt + 11'd1;
            end else begin
              r_ovf <= 1'b1;
            end
            if (w_begin_fall) r_fall_pend <= 1'b1;
          end else if (w_end_frame) begin
            r_fall_pend <= 1'b0;
            if (w_runt) begin
              if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
            end else begin
              r_next_page <= w_np;
              r_total     <= w_total;
              r_hcnt      <= 2'd0;
            end
          end
        end
        S_HDR: r_hcnt <= r_hcnt + 2'd1;
        S_READY: if (w_begin_rise && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
        default: ;
      endcase
    end
  end

  // Header bytes are driven straight from the HDR state so they occupy the
  // four cycles immediately after the end of frame is seen.
  always_comb begin
    buf_addr = r_addr;
    buf_data = r_data;
    if (r_state == S_HDR) begin
      buf_addr = {9'd0, r_hcnt};
      case (r_hcnt)
        2'd0:    buf_data = r_ovf ? 8'h21 : 8'h01;
        2'd1:    buf_data = r_next_page;
        2'd2:    buf_data = r_total[7:0];
        default: buf_data = {5'd0, r_total[10:8]};
      endcase
    end
  end

  assign buf_we      = r_we | (r_state == S_HDR);
  assign frame_valid = (r_state == S_READY);
  assign frame_len   = r_cnt;
  assign next_page   = r_next_page;
  assign drop_cnt    = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_ethernec_rx_framer.sv
// ============================================================================
//  Module   : tb_ethernec_rx_framer
//  Brief    : Scoreboard bench for ethernec_rx_framer with a frame-level model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ethernec_rx_framer;

  localparam int FRAMESIZE = 1536;
  localparam int MINFRAME  = 14;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_begin = 1'b0, rx_strobe = 1'b0;
  logic [7:0]  rx_byte = '0, curr = 8'h4C, pstart = 8'h4C, pstop = 8'h80;
  logic        buf_we, frame_valid, frame_ack = 1'b0;
  logic [10:0] buf_addr, frame_len;
  logic [7:0]  buf_data, next_page, drop_cnt;

  always #5 clk = ~clk;

  ethernec_rx_framer #(.FRAMESIZE(FRAMESIZE), .MINFRAME(MINFRAME)) dut (
    .clk(clk), .reset(reset), .rx_begin(rx_begin), .rx_strobe(rx_strobe),
    .rx_byte(rx_byte), .curr(curr), .pstart(pstart), .pstop(pstop),
    .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data),
    .frame_valid(frame_valid), .frame_len(frame_len), .next_page(next_page),
    .frame_ack(frame_ack), .drop_cnt(drop_cnt)
  );

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int len;  int np;   } fr_t;
  wr_t exp_wr[$];
  fr_t exp_fr[$];

  int checks = 0, failures = 0;
  int m_drop = 0;
  bit m_busy = 0;
  bit prev_fv = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: pops expected buffer writes and completed-frame descriptors.
  always @(negedge clk) begin
    if (buf_we === 1'b1) begin
      if (exp_wr.size() == 0) begin
        check("unexpected_write_addr", {21'd0, buf_addr}, 32'hFFFF_FFFF);
      end else begin
        wr_t w;
        w = exp_wr.pop_front();
        check("wr_addr", {21'd0, buf_addr}, w.addr);
        check("wr_data", {24'd0, buf_data}, w.data);
      end
    end
    if (frame_valid === 1'b1 && !prev_fv) begin
      if (exp_fr.size() == 0) begin
        check("unexpected_frame_len", {21'd0, frame_len}, 32'hFFFF_FFFF);
      end else begin
        fr_t f;
        f = exp_fr.pop_front();
        check("frame_len", {21'd0, frame_len}, f.len);
        check("next_page", {24'd0, next_page}, f.np);
      end
    end
    prev_fv = (frame_valid === 1'b1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte   = b;
    rx_strobe = 1'b1;
    repeat (3) tick();
    rx_strobe = 1'b0;
    repeat (3) tick();
  endtask

  function automatic void bump_drop();
    if (m_drop < 255) m_drop++;
  endfunction

  // mode 0: incrementing bytes, mode 1: random bytes
  task automatic run_frame(input int n, input int mode);
    logic [7:0] data[$];
    bit accepted;
    int kept, total, pages, np, k;
    for (int i = 0; i < n; i++) data.push_back(mode == 0 ? 8'(i) : 8'($urandom));
    accepted = 0;
    if (m_busy) begin
      bump_drop();
    end else begin
      kept = (n < FRAMESIZE) ? n : FRAMESIZE;
      for (int i = 0; i < kept; i++) exp_wr.push_back('{4 + i, int'(data[i])});
      if (n < MINFRAME) begin
        bump_drop();
      end else begin
        total = kept + 4;
        pages = (total + 255) / 256;
        np = int'(curr) + pages;
        if (np >= int'(pstop)) np = np - int'(pstop) + int'(pstart);
        exp_wr.push_back('{0, (n > FRAMESIZE) ? 8'h21 : 8'h01});
        exp_wr.push_back('{1, np});
        exp_wr.push_back('{2, total % 256});
        exp_wr.push_back('{3, total / 256});
        exp_fr.push_back('{kept, np});
        m_busy = 1;
        accepted = 1;
      end
    end
    rx_begin = 1'b1;
    repeat (5) tick();
    foreach (data[i]) send_byte(data[i]);
    repeat (2) tick();
    rx_begin = 1'b0;
    if (accepted) begin
      k = 0;
      while (frame_valid !== 1'b1 && k < 40) begin
        tick();
        k++;
      end
      check("fv_latency", k, 7);
    end else begin
      repeat (8) tick();
      check("fv_level", {31'd0, frame_valid}, {31'd0, m_busy});
    end
    check("drop_cnt", {24'd0, drop_cnt}, m_drop);
  endtask

  task automatic do_ack;
    frame_ack = 1'b1;
    tick();
    frame_ack = 1'b0;
    check("fv_after_ack", {31'd0, frame_valid}, 0);
    m_busy = 0;
    tick();
  endtask

  task automatic check_reset_vals;
    check("rst_buf_we", {31'd0, buf_we}, 0);
    check("rst_buf_addr", {21'd0, buf_addr}, 0);
    check("rst_buf_data", {24'd0, buf_data}, 0);
    check("rst_frame_valid", {31'd0, frame_valid}, 0);
    check("rst_frame_len", {21'd0, frame_len}, 0);
    check("rst_next_page", {24'd0, next_page}, 0);
    check("rst_drop_cnt", {24'd0, drop_cnt}, 0);
  endtask

  initial begin
    repeat (5) tick();
    check_reset_vals();
    reset = 1'b0;
    repeat (2) tick();

    // 64-byte frame, then ring wrap, then overflow
    run_frame(64, 0);
    do_ack();
    curr = 8'h7E;
    run_frame(1500, 1);
    do_ack();
    curr = 8'h4C;
    run_frame(1600, 1);
    do_ack();

    // runt
    run_frame(10, 0);

    // busy drop, then a third frame after ack
    run_frame(64, 1);
    run_frame(64, 1);
    check("busy_fv_held", {31'd0, frame_valid}, 1);
    do_ack();
    run_frame(40, 1);
    do_ack();

    // reset in the middle of a frame with begin held high
    rx_begin = 1'b1;
    repeat (5) tick();
    for (int i = 0; i < 20; i++) begin
      exp_wr.push_back('{4 + i, 8'(i + 100)});
      send_byte(8'(i + 100));
    end
    reset = 1'b1;
    tick();
    m_drop = 0;
    m_busy = 0;
    check_reset_vals();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(8'(i));
    rx_begin = 1'b0;
    repeat (8) tick();
    check("post_reset_fv", {31'd0, frame_valid}, 0);
    check("post_reset_drop", {24'd0, drop_cnt}, 0);

    // randomized ring geometry and lengths
    for (int r = 0; r < 5; r++) begin
      pstart = 8'($urandom_range(8'h40, 8'h60));
      pstop  = 8'($urandom_range(8'h70, 8'hC0));
      curr   = 8'($urandom_range(int'(pstop) - 8, int'(pstop) - 1));
      run_frame($urandom_range(0, 90), 1);
      if (m_busy) do_ack();
    end

    // saturate drop counter with empty frames
    for (int r = 0; r < 260; r++) run_frame(0, 0);
    check("drop_saturated", {24'd0, drop_cnt}, 255);

    repeat (4) tick();
    check("wr_queue_empty", exp_wr.size(), 0);
    check("fr_queue_empty", exp_fr.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
